// File: rtl/coef_reload_streamer.sv
// coef_reload_streamer: buffers FIR coefficients, streams them as a reload packet,
// then issues the config beat that commits the new coefficient set.
module coef_reload_streamer #(
  parameter int COEF_WIDTH = 16,
  parameter int MAX_COEFS = 64,
  parameter int CNT_WIDTH = 7,
  parameter logic [7:0] CONFIG_WORD = 8'h00
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic coef_wr,
  input  logic [COEF_WIDTH-1:0] coef_wdata,
  input  logic start,
  input  logic err_clr,
  output logic [CNT_WIDTH-1:0] coef_count,
  output logic busy,
  output logic done,
  output logic err_ovf,
  output logic err_busy,
  output logic err_empty,
  output logic [COEF_WIDTH-1:0] m_axis_reload_tdata,
  output logic m_axis_reload_tvalid,
  output logic m_axis_reload_tlast,
  input  logic m_axis_reload_tready,
  output logic [7:0] m_axis_config_tdata,
  output logic m_axis_config_tvalid,
  input  logic m_axis_config_tready
);
  localparam int AW = $clog2(MAX_COEFS);
  typedef enum logic [1:0] {IDLE, RELOAD, CONFIG} state_t;
  state_t state;
  logic [CNT_WIDTH-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [COEF_WIDTH-1:0] mem [MAX_COEFS];
  logic idle, full, wr_ok, ovf_set, busy_set, empty_set, go;
  assign idle = state == IDLE;
  assign full = count == CNT_WIDTH'(MAX_COEFS);
  assign wr_ok = idle && coef_wr && !full;
  assign ovf_set = idle && coef_wr && full;
  assign busy_set = !idle && (coef_wr || start);
  // a write accepted in the same cycle as start counts toward the packet
  assign go = idle && start && (count != '0 || wr_ok);
  assign empty_set = idle && start && !go;
  assign coef_count = count;
  assign busy = !idle;
  assign m_axis_reload_tvalid = state == RELOAD;
  assign m_axis_reload_tdata = m_axis_reload_tvalid ? mem[rd_ptr] : '0;
  assign m_axis_reload_tlast = m_axis_reload_tvalid && (CNT_WIDTH'(rd_ptr) == count - CNT_WIDTH'(1));
  assign m_axis_config_tvalid = state == CONFIG;
  assign m_axis_config_tdata = CONFIG_WORD;
  always_ff @(posedge ACLK)
    if (wr_ok) mem[count[AW-1:0]] <= coef_wdata;
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state <= IDLE;
      count <= '0;
      rd_ptr <= '0;
      done <= 1'b0;
      err_ovf <= 1'b0;
      err_busy <= 1'b0;
      err_empty <= 1'b0;
    end else begin
      done <= 1'b0;
      err_ovf <= ovf_set || (err_ovf && !err_clr);
      err_busy <= busy_set || (err_busy && !err_clr);
      err_empty <= empty_set || (err_empty && !err_clr);
      case (state)
        IDLE: begin
          if (wr_ok) count <= count + CNT_WIDTH'(1);
          if (go) begin
            rd_ptr <= '0;
            state <= RELOAD;
          end
        end
        RELOAD: if (m_axis_reload_tready) begin
          rd_ptr <= rd_ptr + AW'(1);
          if (m_axis_reload_tlast) state <= CONFIG;
        end
        CONFIG: if (m_axis_config_tready) begin
          done <= 1'b1;
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
